alu_exec_unit: RTL and testbench

//  Executes the 4-bit ALU operation code produced by the CPU's ALU-control decode on two WIDTH-bit operands.

---
 rtl/alu_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result channel between register-read and the ALU execute unit.
// Two valid/ready handshakes: operands in, result plus branch flags out.
interface alu_if #(
  parameter int WIDTH = 24
);
  logic             in_vld;
  logic             in_rdy;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             bad_op;

  modport master (
    output in_vld, alu_ctl, a, b, out_rdy,
    input  in_rdy, out_vld, result, zero, ovf, bad_op
  );

  modport slave (
    input  in_vld, alu_ctl, a, b, out_rdy,
    output in_rdy, out_vld, result, zero, ovf, bad_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: AND/OR/ADD/SUB/SLT in 1 cycle, MUL in WIDTH+1 cycles, SLL in shamt+1 cycles.
// One op in flight; in_rdy stays low until the result is taken, out_vld holds outputs under backpressure.
module alu_exec_unit #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input logic  i_clk,
  input logic  i_rst_n,
  alu_if.slave io_alu
);

  localparam int CW = (SHW > $clog2(WIDTH + 1)) ? SHW : $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_rdy;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_bad_op;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_last;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_mp;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_ovf;
  logic             w_sc_bad;
  logic             w_multi;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_sh_next;
  logic [WIDTH-1:0] w_exec_res;
  logic             w_last;

  assign w_accept  = io_alu.in_vld & r_in_rdy;
  assign w_shamt   = io_alu.b[SHW-1:0];
  assign w_sum     = io_alu.a + io_alu.b;
  assign w_diff    = io_alu.a - io_alu.b;
  assign w_add_ovf = (io_alu.a[WIDTH-1] == io_alu.b[WIDTH-1]) && (w_sum[WIDTH-1] != io_alu.a[WIDTH-1]);
  assign w_sub_ovf = (io_alu.a[WIDTH-1] != io_alu.b[WIDTH-1]) && (w_diff[WIDTH-1] != io_alu.a[WIDTH-1]);
  assign w_slt     = $signed(io_alu.a) < $signed(io_alu.b);

  // Single-cycle results; a zero-distance SLL is just a pass-through of A.
  always_comb begin
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    w_sc_bad = 1'b0;
    w_multi  = 1'b0;
    case (io_alu.alu_ctl)
      OP_AND: w_sc_res = io_alu.a & io_alu.b;
      OP_OR:  w_sc_res = io_alu.a | io_alu.b;
      OP_ADD: begin
        w_sc_res = w_sum;
        w_sc_ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_sc_res = w_diff;
        w_sc_ovf = w_sub_ovf;
      end
      OP_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_MUL: w_multi = 1'b1;
      OP_SLL: begin
        w_sc_res = io_alu.a;
        w_multi  = (w_shamt != '0);
      end
      default: w_sc_bad = 1'b1;
    endcase
  end

  // r_sh is the left-shifting multiplicand for MUL and the shifted value for SLL.
  assign w_mul_acc  = r_acc + (r_mp[0] ? r_sh : '0);
  assign w_sh_next  = r_sh << 1;
  assign w_exec_res = (r_op == OP_MUL) ? w_mul_acc : w_sh_next;
  assign w_last     = (r_cnt == r_last);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_ovf     <= 1'b0;
      r_bad_op  <= 1'b0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_sh      <= '0;
      r_mp      <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_rdy <= 1'b0;
            r_op     <= io_alu.alu_ctl;
            r_cnt    <= '0;
            if (w_multi) begin
              r_state <= S_EXEC;
              r_sh    <= io_alu.a;
              r_mp    <= io_alu.b;
              r_acc   <= '0;
              r_last  <= (io_alu.alu_ctl == OP_MUL) ? CW'(WIDTH - 1) : CW'(w_shamt) - CW'(1);
            end else begin
              r_state   <= S_DONE;
              r_out_vld <= 1'b1;
              r_result  <= w_sc_res;
              r_zero    <= (w_sc_res == '0);
              r_ovf     <= w_sc_ovf;
              r_bad_op  <= w_sc_bad;
            end
          end
        end
        S_EXEC: begin
          r_sh  <= w_sh_next;
          r_mp  <= r_mp >> 1;
          r_acc <= w_mul_acc;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state   <= S_DONE;
            r_out_vld <= 1'b1;
            r_result  <= w_exec_res;
            r_zero    <= (w_exec_res == '0);
            r_ovf     <= 1'b0;
            r_bad_op  <= 1'b0;
          end
        end
        S_DONE: begin
          if (io_alu.out_rdy) begin
            r_state   <= S_IDLE;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_alu.in_rdy  = r_in_rdy;
  assign io_alu.out_vld = r_out_vld;
  assign io_alu.result  = r_result;
  assign io_alu.zero    = r_zero;
  assign io_alu.ovf     = r_ovf;
  assign io_alu.bad_op  = r_bad_op;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random ops against a signed-integer reference model.
// Checks result, flags, latency, output hold under backpressure and mid-operation reset.
module tb_alu_exec_unit;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(W)) alu_bus ();

  alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_alu  (alu_bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sval(input logic [W-1:0] v);
    return v[W-1] ? longint'(v) - (longint'(1) <<< W) : longint'(v);
  endfunction

  // Reference: plain signed/unsigned integer arithmetic on the operand values.
  function automatic void ref_model(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] res, output logic ovf, output logic bad,
                                    output int lat);
    longint sa, sb, s, p;
    int sh;
    sa  = sval(a);
    sb  = sval(b);
    res = '0;
    ovf = 1'b0;
    bad = 1'b0;
    lat = 1;
    case (ctl)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010, 4'b0110: begin
        s   = (ctl == 4'b0010) ? sa + sb : sa - sb;
        res = s[W-1:0];
        ovf = (s > (longint'(1) <<< (W-1)) - 1) || (s < -(longint'(1) <<< (W-1)));
      end
      4'b0111: res = (sa < sb) ? 1 : 0;
      4'b1000: begin
        p   = longint'(a) * longint'(b);
        res = p[W-1:0];
        lat = W + 1;
      end
      4'b1001: begin
        sh  = int'(b[4:0]);
        res = (sh >= W) ? '0 : (a << sh);
        lat = sh + 1;
      end
      default: bad = 1'b1;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input logic pre_rdy);
    logic [W-1:0] e_res;
    logic e_ovf, e_bad, busy_ok, hold_ok;
    int e_lat, lat, guard;
    ref_model(ctl, a, b, e_res, e_ovf, e_bad, e_lat);
    guard = 0;
    while (!alu_bus.in_rdy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_rdy"}, alu_bus.in_rdy, 1);
    alu_bus.in_vld  = 1'b1;
    alu_bus.alu_ctl = ctl;
    alu_bus.a       = a;
    alu_bus.b       = b;
    alu_bus.out_rdy = pre_rdy;
    @(posedge clk); #1;
    alu_bus.in_vld = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    // Junk requests and operand churn while busy must be ignored.
    while (!alu_bus.out_vld && lat <= 64) begin
      if (alu_bus.in_rdy) busy_ok = 1'b0;
      alu_bus.in_vld = 1'($urandom_range(0, 1));
      alu_bus.a      = W'($urandom);
      alu_bus.b      = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    alu_bus.in_vld  = 1'b0;
    alu_bus.out_rdy = 1'b0;
    if (alu_bus.in_rdy) busy_ok = 1'b0;
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " lat"}, lat, e_lat);
    check({tag, " result"}, alu_bus.result, e_res);
    check({tag, " zero"}, alu_bus.zero, (e_res == '0));
    check({tag, " ovf"}, alu_bus.ovf, e_ovf);
    check({tag, " bad"}, alu_bus.bad_op, e_bad);
    if (hold > 0) begin
      hold_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!alu_bus.out_vld || alu_bus.in_rdy || alu_bus.result !== e_res ||
            alu_bus.zero !== (e_res == '0) || alu_bus.ovf !== e_ovf || alu_bus.bad_op !== e_bad)
          hold_ok = 1'b0;
      end
      check({tag, " hold"}, hold_ok, 1);
    end
    alu_bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    alu_bus.out_rdy = 1'b0;
    check({tag, " released"}, {alu_bus.out_vld, alu_bus.in_rdy}, 2'b01);
  endtask

  initial begin
    logic [3:0] ops [8];
    logic [3:0] ctl;
    logic [W-1:0] ra, rb;
    logic stay_idle;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0010};
    alu_bus.in_vld  = 1'b0;
    alu_bus.alu_ctl = '0;
    alu_bus.a       = '0;
    alu_bus.b       = '0;
    alu_bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset", {alu_bus.in_rdy, alu_bus.out_vld, alu_bus.zero, alu_bus.ovf, alu_bus.bad_op}, 5'b10100);
    check("reset result", alu_bus.result, 0);

    do_op("add_ovf", 4'b0010, 24'h7FFFFF, 24'h000001, 0, 1'b1);
    do_op("sub_eq", 4'b0110, 24'h123456, 24'h123456, 0, 1'b0);
    do_op("sub_ovf", 4'b0110, 24'h800000, 24'h000001, 0, 1'b1);
    do_op("slt_neg", 4'b0111, 24'hFFFFFF, 24'h000001, 0, 1'b0);
    do_op("mul", 4'b1000, 24'h000123, 24'h000456, 0, 1'b1);
    do_op("sll5", 4'b1001, 24'h000001, 24'd5, 0, 1'b0);
    do_op("sll0", 4'b1001, 24'h000001, 24'd0, 0, 1'b1);
    do_op("sll30", 4'b1001, 24'h000001, 24'd30, 0, 1'b0);
    do_op("hold", 4'b0010, 24'h00F000, 24'h000F00, 4, 1'b0);
    do_op("badop", 4'b1111, 24'h123456, 24'h654321, 0, 1'b1);

    // Reset while the multiplier is mid-iteration.
    alu_bus.in_vld  = 1'b1;
    alu_bus.alu_ctl = 4'b1000;
    alu_bus.a       = 24'h000777;
    alu_bus.b       = 24'h000999;
    @(posedge clk); #1;
    alu_bus.in_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst state", {alu_bus.in_rdy, alu_bus.out_vld, alu_bus.zero}, 3'b101);
    check("midrst result", alu_bus.result, 0);
    stay_idle = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (alu_bus.out_vld || !alu_bus.in_rdy) stay_idle = 1'b0;
    end
    check("midrst no output", stay_idle, 1);
    do_op("post_rst_bad", 4'b1111, 24'h000001, 24'h000002, 0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      ctl = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: ra = 24'h7FFFFF;
        1: ra = 24'h800000;
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      do_op($sformatf("rnd%0d", i), ctl, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
